// File: rtl/ifu_pkg.sv
// Shared fetch-unit constants and the instruction-buffer entry layout.
package ifu_pkg;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam logic [PC_W-1:0] IFU_RESET_PC = 32'h0000_3000;
  localparam int IFU_DEPTH = 2;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } ifu_entry_t;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    return a & ~PC_W'(3);
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; used for the instruction buffer and the in-flight PC queue.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: credit-limited in-order fetch with PC-tagged buffer and redirect flush.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter int          DEPTH    = IFU_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = $bits(ifu_entry_t);

  logic [PC_W-1:0] pc;
  logic [CW-1:0]   outstanding, drop_cnt;
  logic [CW-1:0]   buf_count, pcq_count;
  logic            buf_full, buf_empty, pcq_full, pcq_empty;
  logic [PC_W-1:0] pcq_head;
  logic [EW-1:0]   buf_push_data, buf_head_raw;
  ifu_entry_t      buf_head, buf_tail;
  logic [CW:0]     credit_used;
  logic            req_fire, rsp_stale, rsp_keep, id_pop;

  // Buffer slots plus requests in flight (stale ones included) may never exceed DEPTH.
  assign credit_used    = {1'b0, buf_count} + {1'b0, outstanding};
  assign imem_req_valid = reset && !redirect_valid && !pcq_full
                          && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = word_align(pc);
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_stale = redirect_valid || (drop_cnt != '0);
  assign rsp_keep  = imem_rsp_valid && !rsp_stale && !pcq_empty;

  assign id_valid = !buf_empty;
  assign id_pop   = id_valid && id_ready;
  assign buf_head = ifu_entry_t'(buf_head_raw);
  assign id_instr = buf_head.instr;
  assign id_pc    = buf_head.pc;

  assign buf_tail      = '{pc: pcq_head, instr: imem_rsp_data};
  assign buf_push_data = buf_tail;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        pc       <= word_align(redirect_pc);
        // A response landing on the redirect edge is already stale.
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) pc <= imem_req_addr + PC_W'(4);
        if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(PC_W)) u_pcq (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (imem_req_addr),
    .pop       (rsp_keep),
    .pop_data  (pcq_head),
    .full      (pcq_full),
    .empty     (pcq_empty),
    .count     (pcq_count)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_ibuf (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (buf_push_data),
    .pop       (id_pop),
    .pop_data  (buf_head_raw),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  // Live tags plus pending drops always account for every outstanding request,
  // and the credit rule keeps a kept response from meeting a full buffer.
  always @(posedge clk) begin
    if (reset) begin
      assert ({1'b0, outstanding} == {1'b0, pcq_count} + {1'b0, drop_cnt});
      assert (!(rsp_keep && buf_full && !id_pop));
    end
  end
endmodule

// File: tb/tb_ifu.sv
// Randomized scoreboard bench for ifu against an address-stream reference model.
module tb_ifu;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  ifu #(.RESET_PC(32'h0000_3000), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } pend_t;

  int          checks = 0, failures = 0;
  pend_t       pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;
  int          occ, epoch, cyc, hs_cnt;
  int          lat_min, lat_max;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5EED;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, update model at posedge.
  task automatic cycle(input bit rdy, input bit idr, input bit redir, input logic [31:0] tgt);
    bit    rv, exp_req, hs, pp;
    pend_t h;
    @(negedge clk);
    imem_req_ready = rdy;
    id_ready       = idr;
    redirect_valid = redir;
    redirect_pc    = tgt;
    rv = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rsp_valid = rv;
    imem_rsp_data  = rv ? mem_word(pend[0].addr) : $urandom;
    #1;
    exp_req = (occ + pend.size() < DEPTH) && !redir;
    chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) chk("req_addr", imem_req_addr, model_pc);
    chk("id_valid", 32'(id_valid), 32'(occ > 0));
    hs = exp_req && rdy;
    pp = (occ > 0) && idr;
    @(posedge clk);
    if (rv) begin
      h = pend.pop_front();
      if (h.epoch == epoch && !redir) occ++;
    end
    if (pp) occ--;
    if (hs) begin
      pend.push_back('{model_pc, epoch, cyc + 1 + int'($urandom_range(lat_max, lat_min))});
      exp_q.push_back(model_pc);
      model_pc += 32'd4;
      hs_cnt++;
    end
    if (redir) begin
      epoch++;
      occ      = 0;
      model_pc = tgt & ~32'd3;
      exp_q.delete();
    end
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_id_valid"},  32'(id_valid), 32'd0);
    chk({tag, "_id_instr"},  id_instr, 32'd0);
    chk({tag, "_id_pc"},     id_pc, 32'd0);
    chk({tag, "_req_addr"},  imem_req_addr, 32'h0000_3000);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0;
    #1 reset = 1'b0;
    #1 check_reset_outputs(tag);
    pend.delete(); exp_q.delete();
    occ = 0; epoch++; model_pc = 32'h0000_3000;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1;
    chk({tag, "_first_req_valid"}, 32'(imem_req_valid), 32'd1);
    chk({tag, "_first_req_addr"},  imem_req_addr, 32'h0000_3000);
  endtask

  // Monitor: every decode handshake must deliver the next expected PC and its word.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (reset && id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL id_unexpected: got pc %h expected none", id_pc);
        end else begin
          e = exp_q.pop_front();
          chk("id_pc", id_pc, e);
          chk("id_instr", id_instr, mem_word(e));
        end
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    imem_req_ready = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    occ = 0; epoch = 0; cyc = 0; hs_cnt = 0; lat_min = 0; lat_max = 0;
    model_pc = 32'h0000_3000;

    #12 check_reset_outputs("rst");
    @(negedge clk) reset = 1'b1;
    #1;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0000_3000);

    // Decode stalled: credit caps requests at DEPTH.
    hs_cnt = 0;
    repeat (10) cycle(1, 0, 0, '0);
    chk("stall_req_count", 32'(hs_cnt), 32'd2);
    #1;
    chk("stall_id_valid", 32'(id_valid), 32'd1);
    chk("stall_id_pc", id_pc, 32'h0000_3000);

    // Streaming with single-cycle memory.
    repeat (30) cycle(1, 1, 0, '0);

    // Redirect with two requests outstanding.
    repeat (6) cycle(0, 1, 0, '0);
    lat_min = 3; lat_max = 3;
    cycle(1, 0, 0, '0);
    cycle(1, 0, 0, '0);
    cycle(0, 0, 1, 32'h0000_3403);
    #1 chk("redir_addr", imem_req_addr, 32'h0000_3400);
    lat_min = 0; lat_max = 2;
    repeat (16) cycle(1, 1, 0, '0);

    // Wrap past the top of the address space.
    cycle(1, 1, 1, 32'hFFFF_FFFC);
    #1 chk("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
    repeat (12) cycle(1, 1, 0, '0);

    // Redirect on a cycle carrying a response and a pop.
    lat_min = 0; lat_max = 0;
    repeat (6) cycle(1, 1, 0, '0);
    cycle(1, 1, 1, 32'h0000_5000);
    repeat (8) cycle(1, 1, 0, '0);

    // Randomized traffic.
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(3, 0))
        0: tgt = 32'hFFFF_FFF8;
        1: tgt = 32'h0000_3403;
        default: tgt = $urandom;
      endcase
      cycle($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0,
            $urandom_range(39, 0) == 0, tgt);
    end

    // Asynchronous reset with two requests in flight.
    repeat (6) cycle(0, 1, 0, '0);
    lat_min = 3; lat_max = 3;
    cycle(1, 0, 0, '0);
    cycle(1, 0, 0, '0);
    do_reset("midrst");
    lat_min = 0; lat_max = 2;
    repeat (40) cycle(1, $urandom_range(1, 0) == 1, 0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
